// File: rtl/rnd_stream_buffer.sv
// Consumer-side FIFO for PRNG randomness words: each word is delivered to the core exactly once.
// Optional stall-cycle counter port enabled by defining RNDBUF_STALL_CNT_EN.
module rnd_stream_buffer #(
  parameter int unsigned RND   = 1024,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [RND-1:0] in_rnd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [RND-1:0] out_rnd,
  input  logic           flush,
  output logic [CW-1:0]  level,
  output logic           underrun
`ifdef RNDBUF_STALL_CNT_EN
  ,
  output logic [15:0]    stall_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW-1:0] PtrOne = CW'(1);

  logic [RND-1:0] mem_q [DEPTH];
  logic [CW-1:0]  wr_ptr_q, rd_ptr_q;
  logic           underrun_q;
  logic           empty, full, push, pop, stall_ev;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[CW-1] != rd_ptr_q[CW-1]);

  // Ready depends on registered state and flush only, never on out_ready.
  assign in_ready  = !full && !flush;
  assign out_valid = !empty;
  assign out_rnd   = mem_q[rd_ptr_q[AW-1:0]];
  assign level     = wr_ptr_q - rd_ptr_q;
  assign underrun  = underrun_q;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready && !flush;
  assign stall_ev = out_ready && !out_valid && !flush;

  // Storage is not reset; stale contents are hidden while out_valid is low.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_rnd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      underrun_q <= 1'b0;
    end else if (flush) begin
      rd_ptr_q   <= wr_ptr_q;
      underrun_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      if (stall_ev) begin
        underrun_q <= 1'b1;
      end
    end
  end

`ifdef RNDBUF_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Flush does not clear the counter; only reset does.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_ev && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rnd_stream_buffer.sv
// Self-checking bench for rnd_stream_buffer: queue-based reference model plus directed and random
// stimulus. Define RNDBUF_STALL_CNT_EN to also cover the stall counter.
module tb_rnd_stream_buffer;

  localparam int unsigned RND   = 128;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [RND-1:0] in_rnd = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [RND-1:0] out_rnd;
  logic           flush = 1'b0;
  logic [CW-1:0]  level;
  logic           underrun;
`ifdef RNDBUF_STALL_CNT_EN
  logic [15:0]    stall_cnt;
`endif

  rnd_stream_buffer #(
    .RND   (RND),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rnd    (in_rnd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rnd   (out_rnd),
    .flush     (flush),
    .level     (level),
    .underrun  (underrun)
`ifdef RNDBUF_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [RND-1:0] act, input logic [RND-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of held words plus sticky flag and saturating counter.
  logic [RND-1:0] mq[$];
  bit             m_known = 1'b0;
  bit             m_under = 1'b0;
  int unsigned    m_stall = 0;
  bit             have, room;
  int unsigned    sz;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_under = 1'b0;
      m_stall = 0;
      m_known = 1'b1;
    end else if (flush) begin
      mq.delete();
      m_under = 1'b0;
    end else begin
      have = (mq.size() > 0);
      room = (mq.size() < DEPTH);
      if (out_ready && !have) begin
        m_under = 1'b1;
        if (m_stall < 65535) m_stall++;
      end
      if (out_ready && have) void'(mq.pop_front());
      if (in_valid && room) mq.push_back(in_rnd);
    end
  end

  always @(negedge clk) begin
    if (m_known && !rst) begin
      sz = mq.size();
      chk("m_in_ready", RND'(in_ready), RND'((sz < DEPTH) && !flush));
      chk("m_out_valid", RND'(out_valid), RND'(sz > 0));
      chk("m_level", RND'(level), RND'(sz));
      chk("m_underrun", RND'(underrun), RND'(m_under));
      if (sz > 0) chk("m_out_rnd", out_rnd, mq[0]);
`ifdef RNDBUF_STALL_CNT_EN
      chk("m_stall_cnt", RND'(stall_cnt), RND'(m_stall));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RND-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [RND-1:0] wa, wb, wc, wd;

  initial begin
    wa = {4{32'hAAAA_0001}};
    wb = {4{32'hBBBB_0002}};
    wc = {4{32'hCCCC_0003}};
    wd = {4{32'hDDDD_0004}};

    // Reset then idle
    step();
    rst = 1'b0;
    step();
    step();
    chk("rst_in_ready", RND'(in_ready), RND'(1));
    chk("rst_out_valid", RND'(out_valid), RND'(0));
    chk("rst_level", RND'(level), RND'(0));
    chk("rst_underrun", RND'(underrun), RND'(0));
`ifdef RNDBUF_STALL_CNT_EN
    chk("rst_stall_cnt", RND'(stall_cnt), RND'(0));
`endif

    // Fill to full; third word is held off
    in_valid = 1'b1; in_rnd = wa;
    step();
    chk("a_latency_valid", RND'(out_valid), RND'(1));
    in_rnd = wb;
    step();
    chk("full_level", RND'(level), RND'(2));
    chk("full_in_ready", RND'(in_ready), RND'(0));
    chk("full_head_a", out_rnd, wa);
    in_rnd = wc;
    step();
    chk("held_level", RND'(level), RND'(2));
    out_ready = 1'b1;
    step();
    chk("pop1_head_b", out_rnd, wb);
    chk("pop1_level", RND'(level), RND'(1));
    step();
    chk("pop2_head_c", out_rnd, wc);
    chk("pop2_level", RND'(level), RND'(1));
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("drain_level", RND'(level), RND'(0));

    // Steady streaming after one prefill
    in_valid = 1'b1; in_rnd = RND'(1000);
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      in_rnd = RND'(1000 + i);
      chk("stream_head", out_rnd, RND'(1000 + i - 1));
      chk("stream_level", RND'(level), RND'(1));
      step();
    end
    in_valid = 1'b0;
    chk("stream_last", out_rnd, RND'(1100));
    step();
    out_ready = 1'b0;
    chk("stream_empty", RND'(out_valid), RND'(0));

    // Underrun with empty buffer for 3 cycles
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
    out_ready = 1'b0;
    chk("ur_underrun", RND'(underrun), RND'(1));
    chk("ur_level", RND'(level), RND'(0));
`ifdef RNDBUF_STALL_CNT_EN
    chk("ur_stall_cnt", RND'(stall_cnt), RND'(3));
`endif

    // Flush with level 2, in_valid and out_ready high
    in_valid = 1'b1; in_rnd = wa;
    step();
    in_rnd = wb;
    step();
    chk("pre_flush_level", RND'(level), RND'(2));
    flush = 1'b1; out_ready = 1'b1; in_rnd = wc;
    #1;
    chk("flush_in_ready", RND'(in_ready), RND'(0));
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_level", RND'(level), RND'(0));
    chk("flush_underrun", RND'(underrun), RND'(0));
    chk("flush_out_valid", RND'(out_valid), RND'(0));
`ifdef RNDBUF_STALL_CNT_EN
    chk("flush_keeps_stall", RND'(stall_cnt), RND'(3));
`endif
    in_valid = 1'b1; in_rnd = wd;
    step();
    in_valid = 1'b0; in_rnd = 'x;
    chk("post_flush_head_d", out_rnd, wd);

    // Reset mid-stream with level 2
    in_valid = 1'b1; in_rnd = wa;
    step();
    in_valid = 1'b0;
    chk("pre_rst_level", RND'(level), RND'(2));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_level", RND'(level), RND'(0));
    chk("mid_rst_out_valid", RND'(out_valid), RND'(0));

    // Random traffic; in_rnd is X whenever in_valid is low
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(99) == 0);
      flush     = ($urandom_range(29) == 0);
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 6);
      in_rnd    = in_valid ? rnd_word() : 'x;
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_rnd = '0;
    step();

`ifdef RNDBUF_STALL_CNT_EN
    // Counter saturation
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 65540; i++) step();
    out_ready = 1'b0;
    chk("stall_saturate", RND'(stall_cnt), RND'(16'hFFFF));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
